// File: rtl/keccak_round_ctrl.sv
// Keccak-p[1600,NUM_ROUNDS] round sequencer: owns the 5x5x64 state and steps an external keccak_step_unit.
// Optional completed-permutation counter (perm_count_o) is enabled by defining KECCAK_ROUND_CTRL_PERF_CNT_EN.

module keccak_round_ctrl #(
  parameter int NUM_ROUNDS = 24,
  localparam int ROW_SIZE = 5,
  localparam int COL_SIZE = 5,
  localparam int LANE_SIZE = 64,
  localparam int STEP_SEL_WIDTH = 3,
  localparam int ROUND_INDEX_SIZE = 5
) (
  input  logic                                             clk_i,
  input  logic                                             rst_ni,
  input  logic                                             in_valid_i,
  output logic                                             in_ready_o,
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] in_state_i,
  output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] step_state_o,
  output logic [STEP_SEL_WIDTH-1:0]                        step_sel_o,
  output logic [ROUND_INDEX_SIZE-1:0]                      round_index_o,
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] step_result_i,
  output logic                                             out_valid_o,
  input  logic                                             out_ready_i,
  output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] out_state_o,
  output logic                                             busy_o
`ifdef KECCAK_ROUND_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]                                      perm_count_o
`endif
);

  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;

  localparam logic [STEP_SEL_WIDTH-1:0] IDLE_STEP  = 3'd0;
  localparam logic [STEP_SEL_WIDTH-1:0] THETA_STEP = 3'd1;
  localparam logic [STEP_SEL_WIDTH-1:0] RHO_STEP   = 3'd2;
  localparam logic [STEP_SEL_WIDTH-1:0] PI_STEP    = 3'd3;
  localparam logic [STEP_SEL_WIDTH-1:0] CHI_STEP   = 3'd4;
  localparam logic [STEP_SEL_WIDTH-1:0] IOTA_STEP  = 3'd5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ROUND_INDEX_SIZE-1:0] LAST_ROUND  = 5'd23;
  localparam logic [ROUND_INDEX_SIZE-1:0] FIRST_ROUND = 5'(24 - NUM_ROUNDS);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 24) begin : g_bad_rounds
    $error("keccak_round_ctrl: NUM_ROUNDS must be within 1..24");
  end

  state_t                        r_state;
  logic [1:0]                    r_fsm;
  logic [STEP_SEL_WIDTH-1:0]     r_step;
  logic [ROUND_INDEX_SIZE-1:0]   r_round;
  logic                          r_in_ready;
  logic                          r_out_valid;
  logic                          r_busy;
  logic [STEP_SEL_WIDTH-1:0]     r_step_sel;

  state_t                        w_state_nxt;
  logic [1:0]                    w_fsm_nxt;
  logic [STEP_SEL_WIDTH-1:0]     w_step_nxt;
  logic [ROUND_INDEX_SIZE-1:0]   w_round_nxt;

  // Next-state decode for the sequencer; a corrupted step code in RUN aborts to IDLE with a cleared state.
  always_comb begin
    w_state_nxt = r_state;
    w_fsm_nxt   = r_fsm;
    w_step_nxt  = r_step;
    w_round_nxt = r_round;
    case (r_fsm)
      S_IDLE: begin
        if (in_valid_i && r_in_ready) begin
          w_state_nxt = in_state_i;
          w_round_nxt = FIRST_ROUND;
          w_step_nxt  = THETA_STEP;
          w_fsm_nxt   = S_RUN;
        end else begin
          w_fsm_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_state_nxt = step_result_i;
        case (r_step)
          THETA_STEP: w_step_nxt = RHO_STEP;
          RHO_STEP:   w_step_nxt = PI_STEP;
          PI_STEP:    w_step_nxt = CHI_STEP;
          CHI_STEP:   w_step_nxt = IOTA_STEP;
          IOTA_STEP: begin
            if (r_round >= LAST_ROUND) begin
              w_fsm_nxt = S_DONE;
            end else begin
              w_round_nxt = r_round + 5'd1;
              w_step_nxt  = THETA_STEP;
            end
          end
          default: begin
            w_fsm_nxt   = S_IDLE;
            w_state_nxt = '0;
          end
        endcase
      end
      S_DONE: begin
        if (out_ready_i) begin
          w_fsm_nxt = S_IDLE;
        end else begin
          w_fsm_nxt = S_DONE;
        end
      end
      default: begin
        w_fsm_nxt   = S_IDLE;
        w_state_nxt = '0;
      end
    endcase
  end

  // State, counters and the registered handshake/status outputs, all decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= '0;
      r_fsm       <= S_IDLE;
      r_step      <= THETA_STEP;
      r_round     <= 5'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_step_sel  <= IDLE_STEP;
    end else begin
      r_state     <= w_state_nxt;
      r_fsm       <= w_fsm_nxt;
      r_step      <= w_step_nxt;
      r_round     <= w_round_nxt;
      r_in_ready  <= (w_fsm_nxt == S_IDLE);
      r_out_valid <= (w_fsm_nxt == S_DONE);
      r_busy      <= (w_fsm_nxt == S_RUN);
      r_step_sel  <= (w_fsm_nxt == S_RUN) ? w_step_nxt : IDLE_STEP;
    end
  end

  assign in_ready_o    = r_in_ready;
  assign out_valid_o   = r_out_valid;
  assign busy_o        = r_busy;
  assign step_sel_o    = r_step_sel;
  assign round_index_o = r_round;
  assign step_state_o  = r_state;
  assign out_state_o   = r_state;

`ifdef KECCAK_ROUND_CTRL_PERF_CNT_EN
  logic        w_out_hs;
  logic [31:0] r_perm_count;

  assign w_out_hs = r_out_valid & out_ready_i;

  // Saturating count of completed output handshakes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perm_count <= 32'd0;
    end else if (w_out_hs && (r_perm_count != 32'hFFFF_FFFF)) begin
      r_perm_count <= r_perm_count + 32'd1;
    end else begin
      r_perm_count <= r_perm_count;
    end
  end

  assign perm_count_o = r_perm_count;
`endif

endmodule
